multi_cycle_ctrl: RTL and testbench

Control FSM for the multi-cycle MIPS core. It sits directly upstream of the data path and drives every mux select, write enable and ALU operation that the data path consumes. It sequences each instruction through IF/ID/EX/MEM/WB states and stalls on the memory/IO ready handshake. It consumes the latched instruction word and the ALU zero/overflow flags that the data path returns.

---
 rtl/multi_cycle_ctrl.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_ctrl.sv
// Control FSM for the multi-cycle MIPS core: sequences IF/ID/EX/MEM/WB and
// decodes every data-path select, strobe and ALU operation from state + IR.
module multi_cycle_ctrl #(
  parameter logic [4:0] RESET_STATE = 5'd0,
  parameter bit         EXC_ENABLE  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MIO_ready,
  input  logic [31:0] Inst_in,
  input  logic        zero,
  input  logic        overflow,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        CPU_MIO,
  output logic        IorD,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  RegDst,
  output logic [1:0]  MemtoReg,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  PCSource,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        Beq,
  output logic        Signext,
  output logic        data2Mem,
  output logic [3:0]  ALU_operation,
  output logic [4:0]  state_out
);

  localparam int unsigned SW = 5;
  localparam int unsigned AW = 4;
  localparam int unsigned OW = 6;

  localparam logic [SW-1:0] S_IF       = 5'd0;
  localparam logic [SW-1:0] S_ID       = 5'd1;
  localparam logic [SW-1:0] S_R_EX     = 5'd2;
  localparam logic [SW-1:0] S_R_WB     = 5'd3;
  localparam logic [SW-1:0] S_I_EX     = 5'd4;
  localparam logic [SW-1:0] S_I_WB     = 5'd5;
  localparam logic [SW-1:0] S_MEM_ADDR = 5'd6;
  localparam logic [SW-1:0] S_MEM_RD   = 5'd7;
  localparam logic [SW-1:0] S_LW_WB    = 5'd8;
  localparam logic [SW-1:0] S_MEM_WR   = 5'd9;
  localparam logic [SW-1:0] S_BRANCH   = 5'd10;
  localparam logic [SW-1:0] S_JUMP     = 5'd11;
  localparam logic [SW-1:0] S_JAL      = 5'd12;
  localparam logic [SW-1:0] S_JR       = 5'd13;
  localparam logic [SW-1:0] S_LUI      = 5'd14;
  localparam logic [SW-1:0] S_EXC      = 5'd15;
  localparam logic [SW-1:0] S_ILLEGAL  = EXC_ENABLE ? S_EXC : S_IF;

  localparam logic [AW-1:0] ALU_AND = 4'd0;
  localparam logic [AW-1:0] ALU_OR  = 4'd1;
  localparam logic [AW-1:0] ALU_ADD = 4'd2;
  localparam logic [AW-1:0] ALU_XOR = 4'd3;
  localparam logic [AW-1:0] ALU_NOR = 4'd4;
  localparam logic [AW-1:0] ALU_SRL = 4'd5;
  localparam logic [AW-1:0] ALU_SUB = 4'd6;
  localparam logic [AW-1:0] ALU_SLT = 4'd7;
  localparam logic [AW-1:0] ALU_SLL = 4'd8;

  localparam logic [OW-1:0] OP_RTYPE = 6'h00;
  localparam logic [OW-1:0] OP_J     = 6'h02;
  localparam logic [OW-1:0] OP_JAL   = 6'h03;
  localparam logic [OW-1:0] OP_BEQ   = 6'h04;
  localparam logic [OW-1:0] OP_BNE   = 6'h05;
  localparam logic [OW-1:0] OP_ADDI  = 6'h08;
  localparam logic [OW-1:0] OP_ADDIU = 6'h09;
  localparam logic [OW-1:0] OP_SLTI  = 6'h0A;
  localparam logic [OW-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OW-1:0] OP_ORI   = 6'h0D;
  localparam logic [OW-1:0] OP_XORI  = 6'h0E;
  localparam logic [OW-1:0] OP_LUI   = 6'h0F;
  localparam logic [OW-1:0] OP_LW    = 6'h23;
  localparam logic [OW-1:0] OP_SW    = 6'h2B;

  localparam logic [OW-1:0] F_SLL  = 6'h00;
  localparam logic [OW-1:0] F_SRL  = 6'h02;
  localparam logic [OW-1:0] F_JR   = 6'h08;
  localparam logic [OW-1:0] F_ADD  = 6'h20;
  localparam logic [OW-1:0] F_ADDU = 6'h21;
  localparam logic [OW-1:0] F_SUB  = 6'h22;
  localparam logic [OW-1:0] F_SUBU = 6'h23;
  localparam logic [OW-1:0] F_AND  = 6'h24;
  localparam logic [OW-1:0] F_OR   = 6'h25;
  localparam logic [OW-1:0] F_XOR  = 6'h26;
  localparam logic [OW-1:0] F_NOR  = 6'h27;
  localparam logic [OW-1:0] F_SLT  = 6'h2A;

  logic [SW-1:0] r_state;
  logic [SW-1:0] w_next;
  logic [OW-1:0] w_op;
  logic [OW-1:0] w_funct;
  logic          w_r_legal;
  logic [AW-1:0] w_r_alu;
  logic          w_r_ovf_chk;
  logic [AW-1:0] w_i_alu;
  logic          w_i_sx;
  logic          w_unused;

  assign w_op        = Inst_in[31:26];
  assign w_funct     = Inst_in[5:0];
  assign w_r_ovf_chk = (w_funct == F_ADD) || (w_funct == F_SUB);
  // zero is consumed by the data path's branch gate; upper IR fields feed it directly
  assign w_unused    = ^{zero, Inst_in[25:6]};

  // R-type funct decode
  always_comb begin
    w_r_legal = 1'b1;
    w_r_alu   = ALU_ADD;
    case (w_funct)
      F_ADD, F_ADDU: w_r_alu = ALU_ADD;
      F_SUB, F_SUBU: w_r_alu = ALU_SUB;
      F_AND:         w_r_alu = ALU_AND;
      F_OR, F_JR:    w_r_alu = ALU_OR;
      F_XOR:         w_r_alu = ALU_XOR;
      F_NOR:         w_r_alu = ALU_NOR;
      F_SLT:         w_r_alu = ALU_SLT;
      F_SLL:         w_r_alu = ALU_SLL;
      F_SRL:         w_r_alu = ALU_SRL;
      default:       w_r_legal = 1'b0;
    endcase
  end

  // I-type ALU op and immediate extension
  always_comb begin
    w_i_alu = ALU_ADD;
    w_i_sx  = 1'b0;
    case (w_op)
      OP_ADDI, OP_ADDIU, OP_LW, OP_SW, OP_BEQ, OP_BNE: w_i_sx = 1'b1;
      OP_SLTI: begin
        w_i_alu = ALU_SLT;
        w_i_sx  = 1'b1;
      end
      OP_ANDI: w_i_alu = ALU_AND;
      OP_ORI:  w_i_alu = ALU_OR;
      OP_XORI: w_i_alu = ALU_XOR;
      default: w_i_alu = ALU_ADD;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= RESET_STATE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IF: if (MIO_ready) w_next = S_ID;
      S_ID: begin
        case (w_op)
          OP_RTYPE: begin
            if (!w_r_legal)            w_next = S_ILLEGAL;
            else if (w_funct == F_JR)  w_next = S_JR;
            else                       w_next = S_R_EX;
          end
          OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: w_next = S_I_EX;
          OP_LUI:         w_next = S_LUI;
          OP_LW, OP_SW:   w_next = S_MEM_ADDR;
          OP_BEQ, OP_BNE: w_next = S_BRANCH;
          OP_J:           w_next = S_JUMP;
          OP_JAL:         w_next = S_JAL;
          default:        w_next = S_ILLEGAL;
        endcase
      end
      S_R_EX:     w_next = (EXC_ENABLE && overflow && w_r_ovf_chk) ? S_EXC : S_R_WB;
      S_I_EX:     w_next = (EXC_ENABLE && overflow && (w_op == OP_ADDI)) ? S_EXC : S_I_WB;
      S_MEM_ADDR: w_next = (w_op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (MIO_ready) w_next = S_LW_WB;
      S_MEM_WR:   if (MIO_ready) w_next = S_IF;
      default:    w_next = S_IF;
    endcase
  end

  // Output decode; everything held at 0 while reset is asserted
  always_comb begin
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    CPU_MIO       = 1'b0;
    IorD          = 1'b0;
    IRWrite       = 1'b0;
    RegWrite      = 1'b0;
    RegDst        = 2'b00;
    MemtoReg      = 2'b00;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    PCSource      = 3'b000;
    PCWrite       = 1'b0;
    PCWriteCond   = 1'b0;
    Beq           = 1'b0;
    Signext       = 1'b0;
    data2Mem      = 1'b0;
    ALU_operation = ALU_AND;
    state_out     = '0;
    if (!reset) begin
      state_out = r_state;
      case (r_state)
        S_IF: begin
          IorD          = 1'b1;
          MemRead       = 1'b1;
          IRWrite       = 1'b1;
          ALUSrcB       = 2'b01;
          ALU_operation = ALU_ADD;
          PCWrite       = 1'b1;
        end
        S_ID: begin
          ALUSrcB       = 2'b11;
          ALU_operation = ALU_ADD;
        end
        S_R_EX: begin
          ALUSrcA       = 2'b01;
          ALU_operation = w_r_alu;
        end
        S_R_WB: begin
          RegDst   = 2'b01;
          RegWrite = 1'b1;
        end
        S_I_EX: begin
          ALUSrcA       = 2'b01;
          ALUSrcB       = 2'b10;
          ALU_operation = w_i_alu;
          Signext       = w_i_sx;
        end
        S_I_WB: RegWrite = 1'b1;
        S_MEM_ADDR: begin
          ALUSrcA       = 2'b01;
          ALUSrcB       = 2'b10;
          ALU_operation = ALU_ADD;
          Signext       = 1'b1;
        end
        S_MEM_RD: MemRead = 1'b1;
        S_LW_WB: begin
          MemtoReg = 2'b01;
          RegWrite = 1'b1;
        end
        S_MEM_WR: MemWrite = 1'b1;
        S_BRANCH: begin
          ALUSrcA       = 2'b01;
          ALU_operation = ALU_SUB;
          PCWriteCond   = 1'b1;
          PCSource      = 3'b001;
          Signext       = 1'b1;
          Beq           = (w_op == OP_BEQ);
        end
        S_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 3'b010;
        end
        S_JAL: begin
          RegDst   = 2'b10;
          MemtoReg = 2'b11;
          RegWrite = 1'b1;
          PCWrite  = 1'b1;
          PCSource = 3'b010;
        end
        S_JR: begin
          ALUSrcA       = 2'b01;
          ALU_operation = ALU_OR;
          PCWrite       = 1'b1;
          PCSource      = 3'b011;
        end
        S_LUI: begin
          MemtoReg = 2'b10;
          RegWrite = 1'b1;
        end
        S_EXC: begin
          PCWrite  = 1'b1;
          PCSource = 3'b100;
        end
        default: state_out = r_state;
      endcase
      CPU_MIO = MemRead | MemWrite;
    end
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Vector-table bench for multi_cycle_ctrl with an expected-value scoreboard.
module tb_multi_cycle_ctrl;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       cpu_mio;
    logic       iord;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [2:0] pc_src;
    logic       pc_write;
    logic       pc_write_cond;
    logic       beq;
    logic       sext;
    logic       d2m;
    logic [3:0] alu;
  } ctl_t;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        ovf;
    logic [31:0] inst;
    logic [4:0]  st;
    logic [3:0]  alu;
    logic        beq;
    logic        sx;
  } vec_t;

  typedef struct {
    int         idx;
    logic [4:0] st;
    ctl_t       ctl;
  } exp_t;

  localparam logic [4:0] IF = 0, ID = 1, REX = 2, RWB = 3, IEX = 4, IWB = 5, MADDR = 6,
                         MRD = 7, LWWB = 8, MWR = 9, BR = 10, JMP = 11, JAL = 12,
                         JR = 13, LUI = 14, EXC = 15;
  localparam logic [3:0] A_AND = 0, A_OR = 1, A_ADD = 2, A_XOR = 3, A_SLL = 8, A_SUB = 6;

  localparam logic [31:0] I_ADD  = 32'h00851020, I_LW   = 32'h8C820004,
                          I_BNE  = 32'h14850003, I_BEQ  = 32'h10850003,
                          I_JAL  = 32'h0C000010, I_ADDI = 32'h20850001,
                          I_BAD  = 32'hFC000000, I_ORI  = 32'h34A50F0F,
                          I_ADDU = 32'h00851021, I_SUB  = 32'h00851022,
                          I_JR   = 32'h03E00008, I_LUI  = 32'h3C051234,
                          I_SLL  = 32'h00041080, I_J    = 32'h08000010,
                          I_BADF = 32'h0085103F, I_SW   = 32'hACA40008;

  logic        clk, reset, MIO_ready, zero, overflow;
  logic [31:0] Inst_in;
  logic        MemRead, MemWrite, CPU_MIO, IorD, IRWrite, RegWrite;
  logic [1:0]  RegDst, MemtoReg, ALUSrcA, ALUSrcB;
  logic [2:0]  PCSource;
  logic        PCWrite, PCWriteCond, Beq, Signext, data2Mem;
  logic [3:0]  ALU_operation;
  logic [4:0]  state_out;
  ctl_t        act;

  int   n_chk  = 0;
  int   n_fail = 0;
  vec_t vecs[$];
  exp_t sbq[$];

  multi_cycle_ctrl dut (
    .clk(clk), .reset(reset), .MIO_ready(MIO_ready), .Inst_in(Inst_in),
    .zero(zero), .overflow(overflow), .MemRead(MemRead), .MemWrite(MemWrite),
    .CPU_MIO(CPU_MIO), .IorD(IorD), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .PCSource(PCSource), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .Beq(Beq),
    .Signext(Signext), .data2Mem(data2Mem), .ALU_operation(ALU_operation),
    .state_out(state_out)
  );

  assign act = {MemRead, MemWrite, CPU_MIO, IorD, IRWrite, RegWrite, RegDst, MemtoReg,
                ALUSrcA, ALUSrcB, PCSource, PCWrite, PCWriteCond, Beq, Signext,
                data2Mem, ALU_operation};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-state control table; instruction-dependent fields come from the vector
  function automatic ctl_t exp_ctl(input logic rst, input logic [4:0] st,
                                   input logic [3:0] alu, input logic beq, input logic sx);
    ctl_t c;
    c = '0;
    if (!rst) begin
      c.alu  = alu;
      c.beq  = beq;
      c.sext = sx;
      case (st)
        IF:    begin c.mem_read = 1; c.cpu_mio = 1; c.iord = 1; c.ir_write = 1;
                     c.src_b = 2'b01; c.pc_write = 1; end
        ID:    c.src_b = 2'b11;
        REX:   c.src_a = 2'b01;
        RWB:   begin c.reg_dst = 2'b01; c.reg_write = 1; end
        IEX:   begin c.src_a = 2'b01; c.src_b = 2'b10; end
        IWB:   c.reg_write = 1;
        MADDR: begin c.src_a = 2'b01; c.src_b = 2'b10; end
        MRD:   begin c.mem_read = 1; c.cpu_mio = 1; end
        LWWB:  begin c.mem_to_reg = 2'b01; c.reg_write = 1; end
        MWR:   begin c.mem_write = 1; c.cpu_mio = 1; end
        BR:    begin c.src_a = 2'b01; c.pc_write_cond = 1; c.pc_src = 3'b001; end
        JMP:   begin c.pc_write = 1; c.pc_src = 3'b010; end
        JAL:   begin c.reg_dst = 2'b10; c.mem_to_reg = 2'b11; c.reg_write = 1;
                     c.pc_write = 1; c.pc_src = 3'b010; end
        JR:    begin c.src_a = 2'b01; c.pc_write = 1; c.pc_src = 3'b011; end
        LUI:   begin c.mem_to_reg = 2'b10; c.reg_write = 1; end
        default: begin c.pc_write = 1; c.pc_src = 3'b100; end
      endcase
    end
    return c;
  endfunction

  function automatic vec_t mkv(input logic rst, input logic rdy, input logic ovf,
                               input logic [31:0] inst, input logic [4:0] st,
                               input logic [3:0] alu, input logic beq, input logic sx);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.ovf = ovf; v.inst = inst;
    v.st = st; v.alu = alu; v.beq = beq; v.sx = sx;
    return v;
  endfunction

  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    @(posedge clk);
    #1;
    reset     = v.rst;
    MIO_ready = v.rdy;
    overflow  = v.ovf;
    Inst_in   = v.inst;
    zero      = 1'($urandom);
    e.idx = idx;
    e.st  = v.rst ? 5'd0 : v.st;
    e.ctl = exp_ctl(v.rst, v.st, v.alu, v.beq, v.sx);
    sbq.push_back(e);
  endtask

  // Scoreboard checker: outputs settle mid-cycle, compare on the falling edge
  always @(negedge clk) begin
    if (sbq.size() != 0) begin
      exp_t e;
      e = sbq.pop_front();
      n_chk++;
      if (state_out !== e.st) begin
        n_fail++;
        $display("FAIL vec%0d state_out: got %0d expected %0d", e.idx, state_out, e.st);
      end
      n_chk++;
      if (act !== e.ctl) begin
        n_fail++;
        $display("FAIL vec%0d controls: got %07h expected %07h (state %0d)",
                 e.idx, act, e.ctl, e.st);
      end
    end
  end

  initial begin
    reset = 1'b1; MIO_ready = 1'b0; Inst_in = '0; overflow = 1'b0; zero = 1'b0;

    // rst rdy ovf inst state alu beq sx
    vecs.push_back(mkv(1, 0, 0, I_ADD,  IF,    A_AND, 0, 0));
    vecs.push_back(mkv(1, 0, 0, I_ADD,  IF,    A_AND, 0, 0));
    vecs.push_back(mkv(0, 0, 0, I_ADD,  IF,    A_ADD, 0, 0));
    vecs.push_back(mkv(0, 0, 0, I_ADD,  IF,    A_ADD, 0, 0));
    vecs.push_back(mkv(0, 0, 0, I_ADD,  IF,    A_ADD, 0, 0));
    vecs.push_back(mkv(0, 1, 0, I_ADD,  IF,    A_ADD, 0, 0));
    vecs.push_back(mkv(0, 0, 0, I_ADD,  ID,    A_ADD, 0, 0));
    vecs.push_back(mkv(0, 0, 0, I_ADD,  REX,   A_ADD, 0, 0));
    vecs.push_back(mkv(0, 1, 0, I_ADD,  RWB,   A_AND, 0, 0));
    vecs.push_back(mkv(0, 1, 0, I_LW,   IF,    A_ADD, 0, 0));
    vecs.push_back(mkv(0, 0, 0, I_LW,   ID,    A_ADD, 0, 0));
    vecs.push_back(mkv(0, 0, 0, I_LW,   MADDR, A_ADD, 0, 1));
    vecs.push_back(mkv(0, 0, 0, I_LW,   MRD,   A_AND, 0, 0));
    vecs.push_back(mkv(0, 0, 0, I_LW,   MRD,   A_AND, 0, 0));
    vecs.push_back(mkv(0, 1, 0, I_LW,   MRD,   A_AND, 0, 0));
    vecs.push_back(mkv(0, 0, 0, I_LW,   LWWB,  A_AND, 0, 0));
    vecs.push_back(mkv(0, 1, 0, I_BNE,  IF,    A_ADD, 0, 0));
    vecs.push_back(mkv(0, 0, 0, I_BNE,  ID,    A_ADD, 0, 0));
    vecs.push_back(mkv(0, 0, 0, I_BNE,  BR,    A_SUB, 0, 1));
    vecs.push_back(mkv(0, 1, 0, I_BEQ,  IF,    A_ADD, 0, 0));
    vecs.push_back(mkv(0, 0, 0, I_BEQ,  ID,    A_ADD, 0, 0));
    vecs.push_back(mkv(0, 0, 0, I_BEQ,  BR,    A_SUB, 1, 1));
    vecs.push_back(mkv(0, 1, 0, I_JAL,  IF,    A_ADD, 0, 0));
    vecs.push_back(mkv(0, 0, 0, I_JAL,  ID,    A_ADD, 0, 0));
    vecs.push_back(mkv(0, 0, 0, I_JAL,  JAL,   A_AND, 0, 0));
    vecs.push_back(mkv(0, 1, 0, I_ADDI, IF,    A_ADD, 0, 0));
    vecs.push_back(mkv(0, 0, 0, I_ADDI, ID,    A_ADD, 0, 0));
    vecs.push_back(mkv(0, 0, 1, I_ADDI, IEX,   A_ADD, 0, 1));
    vecs.push_back(mkv(0, 0, 0, I_ADDI, EXC,   A_AND, 0, 0));
    vecs.push_back(mkv(0, 1, 0, I_BAD,  IF,    A_ADD, 0, 0));
    vecs.push_back(mkv(0, 0, 0, I_BAD,  ID,    A_ADD, 0, 0));
    vecs.push_back(mkv(0, 0, 0, I_BAD,  EXC,   A_AND, 0, 0));
    vecs.push_back(mkv(0, 1, 0, I_ORI,  IF,    A_ADD, 0, 0));
    vecs.push_back(mkv(0, 0, 0, I_ORI,  ID,    A_ADD, 0, 0));
    vecs.push_back(mkv(0, 0, 1, I_ORI,  IEX,   A_OR,  0, 0));
    vecs.push_back(mkv(0, 0, 0, I_ORI,  IWB,   A_AND, 0, 0));
    vecs.push_back(mkv(0, 1, 0, I_ADDU, IF,    A_ADD, 0, 0));
    vecs.push_back(mkv(0, 0, 0, I_ADDU, ID,    A_ADD, 0, 0));
    vecs.push_back(mkv(0, 0, 1, I_ADDU, REX,   A_ADD, 0, 0));
    vecs.push_back(mkv(0, 0, 0, I_ADDU, RWB,   A_AND, 0, 0));
    vecs.push_back(mkv(0, 1, 0, I_SUB,  IF,    A_ADD, 0, 0));
    vecs.push_back(mkv(0, 0, 0, I_SUB,  ID,    A_ADD, 0, 0));
    vecs.push_back(mkv(0, 0, 1, I_SUB,  REX,   A_SUB, 0, 0));
    vecs.push_back(mkv(0, 0, 0, I_SUB,  EXC,   A_AND, 0, 0));
    vecs.push_back(mkv(0, 1, 0, I_JR,   IF,    A_ADD, 0, 0));
    vecs.push_back(mkv(0, 0, 0, I_JR,   ID,    A_ADD, 0, 0));
    vecs.push_back(mkv(0, 0, 0, I_JR,   JR,    A_OR,  0, 0));
    vecs.push_back(mkv(0, 1, 0, I_LUI,  IF,    A_ADD, 0, 0));
    vecs.push_back(mkv(0, 0, 0, I_LUI,  ID,    A_ADD, 0, 0));
    vecs.push_back(mkv(0, 0, 0, I_LUI,  LUI,   A_AND, 0, 0));
    vecs.push_back(mkv(0, 1, 0, I_SLL,  IF,    A_ADD, 0, 0));
    vecs.push_back(mkv(0, 0, 0, I_SLL,  ID,    A_ADD, 0, 0));
    vecs.push_back(mkv(0, 0, 0, I_SLL,  REX,   A_SLL, 0, 0));
    vecs.push_back(mkv(0, 0, 0, I_SLL,  RWB,   A_AND, 0, 0));
    vecs.push_back(mkv(0, 1, 0, I_J,    IF,    A_ADD, 0, 0));
    vecs.push_back(mkv(0, 0, 0, I_J,    ID,    A_ADD, 0, 0));
    vecs.push_back(mkv(0, 0, 0, I_J,    JMP,   A_AND, 0, 0));
    vecs.push_back(mkv(0, 1, 0, I_BADF, IF,    A_ADD, 0, 0));
    vecs.push_back(mkv(0, 0, 0, I_BADF, ID,    A_ADD, 0, 0));
    vecs.push_back(mkv(0, 0, 0, I_BADF, EXC,   A_AND, 0, 0));
    vecs.push_back(mkv(0, 0, 0, I_SW,   IF,    A_ADD, 0, 0));

    foreach (vecs[i]) apply(vecs[i], i);

    // Store stalled on MIO_ready, aborted by reset, then a clean store
    apply(mkv(0, 1, 0, I_SW, IF,    A_ADD, 0, 0), 100);
    apply(mkv(0, 0, 0, I_SW, ID,    A_ADD, 0, 0), 101);
    apply(mkv(0, 0, 0, I_SW, MADDR, A_ADD, 0, 1), 102);
    apply(mkv(0, 0, 0, I_SW, MWR,   A_AND, 0, 0), 103);
    apply(mkv(0, 0, 0, I_SW, MWR,   A_AND, 0, 0), 104);
    apply(mkv(1, 0, 0, I_SW, MWR,   A_AND, 0, 0), 105);
    apply(mkv(0, 0, 0, I_SW, IF,    A_ADD, 0, 0), 106);
    apply(mkv(0, 1, 0, I_SW, IF,    A_ADD, 0, 0), 107);
    apply(mkv(0, 0, 0, I_SW, ID,    A_ADD, 0, 0), 108);
    apply(mkv(0, 0, 0, I_SW, MADDR, A_ADD, 0, 1), 109);
    apply(mkv(0, 1, 0, I_SW, MWR,   A_AND, 0, 0), 110);
    apply(mkv(0, 0, 0, I_SW, IF,    A_ADD, 0, 0), 111);

    for (int k = 0; k < 4 && sbq.size() != 0; k++) begin
      @(negedge clk);
      #1;
    end
    if (sbq.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
